tl_conflict_monitor: RTL and testbench

Safety stage directly downstream of the four-approach traffic light sequencer. Registers the sequencer's four 3-bit lamp codes, checks them every cycle for illegal encodings, conflicting greens, bad yellow phases and stuck sequencing, and passes them to the lamp drivers. On any fault it blocks the illegal pattern and latches into flashing-red failsafe until explicitly cleared. Lamp encoding: 001 green, 010 yellow, 100 red.

---
 rtl/tl_pkg.sv | 35 +++
 rtl/tl_conflict_monitor_checker.sv | 45 ++++
 rtl/tl_conflict_monitor.sv | 177 +++++++++++++++++
 tb/tb_tl_conflict_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light conflict monitor: lamp codes,
// fault codes, monitor states and green-pair bit positions.
package tl_pkg;

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_OFF    = 3'b000;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_ENCODING  = 3'd1;
    localparam logic [2:0] FC_CONFLICT  = 3'd2;
    localparam logic [2:0] FC_YELLOW    = 3'd3;
    localparam logic [2:0] FC_STUCK     = 3'd4;
    localparam logic [2:0] FC_GREEN_RED = 3'd5;

    typedef enum logic [1:0] {
        MS_ARM   = 2'd0,
        MS_RUN   = 2'd1,
        MS_FAULT = 2'd2
    } mon_state_t;

    // Bit positions inside the GREEN_OK allowed-pair mask
    localparam int PAIR_M1M2 = 0;
    localparam int PAIR_M1M3 = 1;
    localparam int PAIR_M1M4 = 2;
    localparam int PAIR_M2M3 = 3;
    localparam int PAIR_M2M4 = 4;
    localparam int PAIR_M3M4 = 5;

    function automatic logic is_onehot3(input logic [2:0] c);
        return (c == LT_GREEN) || (c == LT_YELLOW) || (c == LT_RED);
    endfunction

endpackage

// File: rtl/tl_conflict_monitor_checker.sv
// Per-approach checker: tracks the previous lamp code and how long the
// approach has been yellow, and flags encoding / yellow-phase violations.
module tl_approach_checker
    import tl_pkg::*;
#(
    parameter int MIN_YEL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [2:0] code,
    output logic       bad_enc,
    output logic       bad_yellow,
    output logic       green_to_red,
    output logic       is_green
);

    localparam int YW = $clog2(MIN_YEL + 1);

    logic [2:0]    prev_q;
    logic [YW-1:0] yel_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prev_q  <= LT_RED;
            yel_cnt <= '0;
        end else begin
            prev_q <= code;
            if (code != LT_YELLOW)
                yel_cnt <= '0;
            else if (yel_cnt != YW'(MIN_YEL))
                yel_cnt <= yel_cnt + YW'(1);
        end
    end

    // yel_cnt counts yellow cycles before the current one, so a departure
    // is legal once it has reached MIN_YEL.
    assign bad_enc      = !is_onehot3(code);
    assign bad_yellow   = (prev_q == LT_YELLOW) &&
                          (code == LT_GREEN ||
                           (code != LT_YELLOW && yel_cnt < YW'(MIN_YEL)));
    assign green_to_red = (prev_q == LT_GREEN) && (code == LT_RED);
    assign is_green     = (code == LT_GREEN);

endmodule

// File: rtl/tl_conflict_monitor.sv
// Safety stage between the traffic-light sequencer and the lamp drivers;
// latches into flashing-red failsafe on any fault. Define TL_STRICT_YELLOW_EN
// to also treat a direct green-to-red change as a fault.
//
// state    | meaning
// MS_ARM   | lamps red, checks off, waiting for an all-red input
// MS_RUN   | lamps follow the registered inputs, checks active
// MS_FAULT | lamps flash red/off, code latched until clr_fault
module tl_conflict_monitor
    import tl_pkg::*;
#(
    parameter logic [5:0] GREEN_OK   = 6'b000011,
    parameter int         MIN_YEL    = 2,
    parameter int         MAX_DWELL  = 16,
    parameter int         FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_m1,
    input  logic [2:0] light_m2,
    input  logic [2:0] light_m3,
    input  logic [2:0] light_m4,
    input  logic       clr_fault,
    output logic [2:0] lamp_m1,
    output logic [2:0] lamp_m2,
    output logic [2:0] lamp_m3,
    output logic [2:0] lamp_m4,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] mon_state
);

    localparam int DW = $clog2(MAX_DWELL + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);
    localparam logic [3:0][2:0] ALL_RED = {4{LT_RED}};
    localparam logic [3:0][2:0] ALL_OFF = {4{LT_OFF}};

    logic [3:0][2:0] in_q;
    logic [3:0][2:0] dwell_prev;
    logic [3:0][2:0] lamps_q;
    mon_state_t      state_q;
    logic            fault_q;
    logic [2:0]      code_q;
    logic [DW-1:0]   dwell_cnt;
    logic [FW-1:0]   flash_cnt;
    logic [FW-1:0]   flash_nxt;

    logic [3:0] bad_enc;
    logic [3:0] bad_yel;
    logic [3:0] g2r;
    logic [3:0] grn;
    logic [5:0] green_pair;
    logic       conflict;
    logic       same;
    logic       stuck;
    logic [2:0] det_code;

    always_ff @(posedge clk) begin
        if (rst)
            in_q <= ALL_RED;
        else
            in_q <= {light_m4, light_m3, light_m2, light_m1};
    end

    for (genvar i = 0; i < 4; i++) begin : g_chk
        tl_approach_checker #(.MIN_YEL(MIN_YEL)) u_chk (
            .clk          (clk),
            .rst          (rst),
            .clear        (state_q != MS_RUN),
            .code         (in_q[i]),
            .bad_enc      (bad_enc[i]),
            .bad_yellow   (bad_yel[i]),
            .green_to_red (g2r[i]),
            .is_green     (grn[i])
        );
    end

    assign green_pair[PAIR_M1M2] = grn[0] & grn[1];
    assign green_pair[PAIR_M1M3] = grn[0] & grn[2];
    assign green_pair[PAIR_M1M4] = grn[0] & grn[3];
    assign green_pair[PAIR_M2M3] = grn[1] & grn[2];
    assign green_pair[PAIR_M2M4] = grn[1] & grn[3];
    assign green_pair[PAIR_M3M4] = grn[2] & grn[3];
    assign conflict = |(green_pair & ~GREEN_OK);

    // Stuck fires on the cycle whose increment would bring the count to MAX_DWELL
    assign same  = (in_q == dwell_prev);
    assign stuck = same && (dwell_cnt == DW'(MAX_DWELL - 1));

`ifdef TL_STRICT_YELLOW_EN
    always_comb begin
        det_code = FC_NONE;
        if (|bad_enc)      det_code = FC_ENCODING;
        else if (conflict) det_code = FC_CONFLICT;
        else if (|bad_yel) det_code = FC_YELLOW;
        else if (stuck)    det_code = FC_STUCK;
        else if (|g2r)     det_code = FC_GREEN_RED;
    end
`else
    logic g2r_unused;
    assign g2r_unused = |g2r;

    always_comb begin
        det_code = FC_NONE;
        if (|bad_enc)      det_code = FC_ENCODING;
        else if (conflict) det_code = FC_CONFLICT;
        else if (|bad_yel) det_code = FC_YELLOW;
        else if (stuck)    det_code = FC_STUCK;
    end
`endif

    assign flash_nxt = (flash_cnt == FW'(2 * FLASH_HALF - 1)) ? '0 : flash_cnt + FW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MS_ARM;
            lamps_q    <= ALL_RED;
            fault_q    <= 1'b0;
            code_q     <= FC_NONE;
            flash_cnt  <= '0;
            dwell_cnt  <= '0;
            dwell_prev <= ALL_RED;
        end else begin
            case (state_q)
                MS_ARM: begin
                    dwell_cnt  <= '0;
                    dwell_prev <= ALL_RED;
                    lamps_q    <= ALL_RED;
                    if (in_q == ALL_RED) begin
                        state_q <= MS_RUN;
                        lamps_q <= in_q;
                    end
                end
                MS_RUN: begin
                    dwell_prev <= in_q;
                    dwell_cnt  <= same ? dwell_cnt + DW'(1) : '0;
                    if (det_code != FC_NONE) begin
                        state_q   <= MS_FAULT;
                        lamps_q   <= ALL_RED;
                        fault_q   <= 1'b1;
                        code_q    <= det_code;
                        flash_cnt <= '0;
                    end else begin
                        lamps_q <= in_q;
                    end
                end
                MS_FAULT: begin
                    dwell_cnt  <= '0;
                    dwell_prev <= ALL_RED;
                    if (clr_fault) begin
                        state_q   <= MS_ARM;
                        lamps_q   <= ALL_RED;
                        fault_q   <= 1'b0;
                        code_q    <= FC_NONE;
                        flash_cnt <= '0;
                    end else begin
                        flash_cnt <= flash_nxt;
                        lamps_q   <= (flash_nxt < FW'(FLASH_HALF)) ? ALL_RED : ALL_OFF;
                    end
                end
                default: begin
                    state_q <= MS_ARM;
                    lamps_q <= ALL_RED;
                end
            endcase
        end
    end

    assign lamp_m1    = lamps_q[0];
    assign lamp_m2    = lamps_q[1];
    assign lamp_m3    = lamps_q[2];
    assign lamp_m4    = lamps_q[3];
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign mon_state  = state_q;

endmodule

// File: tb/tb_tl_conflict_monitor.sv
// Scoreboard bench for tl_conflict_monitor: stimulus queues expected outputs
// tagged with the cycle they must appear on; a monitor pops and compares.
module tb_tl_conflict_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam logic [11:0] RED12 = {R, R, R, R};
    localparam logic [1:0] S_ARM = 2'd0, S_RUN = 2'd1, S_FAULT = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] light_m1 = R, light_m2 = R, light_m3 = R, light_m4 = R;
    logic       clr_fault = 1'b0;
    logic [2:0] lamp_m1, lamp_m2, lamp_m3, lamp_m4;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] mon_state;

    tl_conflict_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .light_m1   (light_m1),
        .light_m2   (light_m2),
        .light_m3   (light_m3),
        .light_m4   (light_m4),
        .clr_fault  (clr_fault),
        .lamp_m1    (lamp_m1),
        .lamp_m2    (lamp_m2),
        .lamp_m3    (lamp_m3),
        .lamp_m4    (lamp_m4),
        .fault      (fault),
        .fault_code (fault_code),
        .mon_state  (mon_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [11:0] lamps;
        logic        flt;
        logic [2:0]  code;
        logic [1:0]  st;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int t, input logic [11:0] l, input logic f,
                             input logic [2:0] c, input logic [1:0] s, input string tag);
        exp_t e;
        e.t = t; e.lamps = l; e.flt = f; e.code = c; e.st = s; e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            act = {lamp_m1, lamp_m2, lamp_m3, lamp_m4};
            while (sb.size() > 0 && sb[0].t <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.t != cyc) begin
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.tag, e.t, cyc);
                end else if (act !== e.lamps || fault !== e.flt || fault_code !== e.code ||
                             mon_state !== e.st) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: lamps=%h want %h fault=%b want %b code=%0d want %0d state=%0d want %0d",
                             e.tag, cyc, act, e.lamps, fault, e.flt, fault_code, e.code, mon_state, e.st);
                end
            end
        end
    end

    task automatic drive(input logic [11:0] l);
        {light_m1, light_m2, light_m3, light_m4} = l;
    endtask

    // Legal vector: appears on the lamps two edges after it is driven
    task automatic pass(input logic [11:0] l, input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            drive(l);
            expect_at(cyc + 2, l, 1'b0, 3'd0, S_RUN, tag);
        end
    endtask

    // Offending vector: fault entry two edges later, then 4 red / 4 dark flashes
    task automatic trip(input logic [11:0] l, input logic [2:0] code, input int nflash, input string tag);
        int n;
        @(negedge clk);
        drive(l);
        n = cyc;
        for (int k = 0; k < nflash; k++)
            expect_at(n + 2 + k, ((k % 8) < 4) ? RED12 : 12'h000, 1'b1, code, S_FAULT, tag);
        @(negedge clk);
        drive(RED12);
        while (cyc < n + 1 + nflash) @(negedge clk);
    endtask

    // Called on a negedge: clear (or reset) now, ARM next edge, RUN the edge after
    task automatic recover(input logic use_rst, input string tag);
        drive(RED12);
        if (use_rst) rst = 1'b1; else clr_fault = 1'b1;
        expect_at(cyc + 1, RED12, 1'b0, 3'd0, S_ARM, tag);
        @(negedge clk);
        rst = 1'b0;
        clr_fault = 1'b0;
        expect_at(cyc + 1, RED12, 1'b0, 3'd0, S_RUN, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        drive(RED12);
        repeat (2) @(negedge clk);
        expect_at(cyc + 1, RED12, 1'b0, 3'd0, S_ARM, "reset");
        @(negedge clk);
        rst = 1'b0;
        expect_at(cyc + 1, RED12, 1'b0, 3'd0, S_RUN, "arm_to_run");

        pass(RED12, 1, "all_red");
        for (int r = 0; r < 3; r++) begin
            pass({G, G, R, R}, 4, "seq_g12");
            pass({G, Y, R, R}, 7, "seq_y2");
            pass({G, R, G, R}, 5, "seq_g13");
            pass({Y, R, Y, R}, 3, "seq_y13");
            pass({R, R, R, G}, 6, "seq_g4");
            pass(RED12, 4, "seq_red");
        end

        clr_fault = 1'b1;
        pass(RED12, 2, "clr_in_run");
        clr_fault = 1'b0;

        trip({R, G, G, R}, 3'd2, 10, "conflict");
        @(negedge clk);
        recover(1'b0, "clear_conflict");

        pass(RED12, 2, "pre_prio");
        trip({R, G, G, 3'b011}, 3'd1, 3, "priority");
        recover(1'b0, "clear_prio");

        pass(RED12, 2, "pre_short_yel");
        pass({Y, R, R, R}, 1, "short_yel");
        trip(RED12, 3'd3, 3, "short_yel_exit");
        recover(1'b0, "clear_short_yel");

        pass(RED12, 2, "pre_yel_green");
        pass({Y, R, R, R}, 3, "yel_hold");
        trip({G, R, R, R}, 3'd3, 3, "yel_to_green");
        recover(1'b0, "clear_yel_green");

        pass(RED12, 1, "pre_dwell");
        pass({G, R, R, R}, 16, "dwell_ok");
        trip({G, R, R, R}, 3'd4, 3, "stuck");
        recover(1'b0, "clear_stuck");

        pass(RED12, 1, "pre_g2r");
        pass({R, R, R, G}, 2, "m4_green");
`ifdef TL_STRICT_YELLOW_EN
        trip(RED12, 3'd5, 3, "green_to_red");
        recover(1'b0, "clear_g2r");
`else
        pass(RED12, 3, "green_to_red_ok");
`endif

        pass(RED12, 1, "pre_rst_flash");
        trip({G, R, R, G}, 3'd2, 6, "conflict_m1m4");
        recover(1'b1, "rst_mid_flash");
        pass({G, G, R, R}, 3, "after_rst");

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
